// File: rtl/alarm_zone_ctrl_if.sv
// alarm_zone_ctrl_if: sensor, control and status bundle of the alarm controller
interface alarm_zone_ctrl_if #(parameter int N_ZONES = 4);
  logic [N_ZONES-1:0] zone_in;
  logic [N_ZONES-1:0] zone_en;
  logic               arm;
  logic               disarm;
  logic               panic;
  logic               siren;
  logic               chime;
  logic               arm_fail;
  logic [2:0]         state;
  logic [N_ZONES-1:0] alarm_zones;
  modport master (
    output zone_in, zone_en, arm, disarm, panic,
    input  siren, chime, arm_fail, state, alarm_zones
  );
  modport slave (
    input  zone_in, zone_en, arm, disarm, panic,
    output siren, chime, arm_fail, state, alarm_zones
  );
endinterface

// File: rtl/alarm_zone_ctrl.sv
// alarm_zone_ctrl: multi-zone intruder alarm with debounce, exit/entry delays, timed siren and zone latch
module alarm_zone_ctrl #(
  parameter int N_ZONES      = 4,
  parameter int ENTRY_ZONE   = 0,
  parameter int DEBOUNCE_CYC = 4,
  parameter int EXIT_DELAY   = 32,
  parameter int ENTRY_DELAY  = 16,
  parameter int SIREN_TIME   = 64
) (
  input logic              clk,
  input logic              rst_n,
  alarm_zone_ctrl_if.slave bus
);
  localparam int MAX_A = EXIT_DELAY > ENTRY_DELAY ? EXIT_DELAY : ENTRY_DELAY;
  localparam int MAX_D = MAX_A > SIREN_TIME ? MAX_A : SIREN_TIME;
  localparam int DW    = $clog2(MAX_D) + 1;
  localparam int CW    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [N_ZONES-1:0] ENTRY_M = N_ZONES'(1 << ENTRY_ZONE);
  typedef enum logic [2:0] {
    DISARMED = 3'd0, EXIT = 3'd1, ARMED = 3'd2, ENTRY = 3'd3, ALARM = 3'd4, SILENCED = 3'd5
  } state_t;
  state_t             state_q, state_d;
  logic [N_ZONES-1:0] zs1_q, zs2_q, az_q, az_d, act;
  logic               ps1_q, ps2_q, arm_fail_q, arm_fail_d;
  logic [CW-1:0]      cnt_q [N_ZONES];
  logic [CW-1:0]      cnt_d [N_ZONES];
  logic [DW-1:0]      dly_q, dly_d;
  // per-zone saturating debounce counter and masked active vector
  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      cnt_d[i] = !zs2_q[i] ? '0 : (cnt_q[i] == CW'(DEBOUNCE_CYC) ? cnt_q[i] : cnt_q[i] + 1'b1);
      act[i]   = (cnt_q[i] == CW'(DEBOUNCE_CYC)) & bus.zone_en[i];
    end
  end
  // next state with disarm > panic > normal transitions; delay reloads on every state change
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q - 1'b1;
    arm_fail_d = 1'b0;
    if (bus.disarm) state_d = DISARMED;
    else if (ps2_q && state_q != ALARM) state_d = ALARM;
    else begin
      case (state_q)
        DISARMED: if (bus.arm) begin
          if (|act) arm_fail_d = 1'b1;
          else state_d = EXIT;
        end
        EXIT:     if (dly_q == '0) state_d = ARMED;
        ARMED:    state_d = |(act & ~ENTRY_M) ? ALARM : (|(act & ENTRY_M) ? ENTRY : ARMED);
        ENTRY:    if (|(act & ~ENTRY_M) || dly_q == '0) state_d = ALARM;
        ALARM:    if (dly_q == '0) state_d = SILENCED;
        SILENCED: if (|(act & ~az_q)) state_d = ALARM;
        default:  state_d = DISARMED;
      endcase
    end
    if (state_d != state_q)
      dly_d = state_d == EXIT  ? DW'(EXIT_DELAY - 1) :
              state_d == ENTRY ? DW'(ENTRY_DELAY - 1) : DW'(SIREN_TIME - 1);
    az_d = bus.disarm ? '0 :
           (state_d == ALARM || state_q == ALARM || state_q == SILENCED) ? az_q | act : az_q;
  end
  // synchronisers, debounce counters, FSM, delay counter and zone latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zs1_q      <= '0;
      zs2_q      <= '0;
      ps1_q      <= 1'b0;
      ps2_q      <= 1'b0;
      cnt_q      <= '{default: '0};
      state_q    <= DISARMED;
      dly_q      <= '0;
      az_q       <= '0;
      arm_fail_q <= 1'b0;
    end else begin
      zs1_q      <= bus.zone_in;
      zs2_q      <= zs1_q;
      ps1_q      <= bus.panic;
      ps2_q      <= ps1_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      dly_q      <= dly_d;
      az_q       <= az_d;
      arm_fail_q <= arm_fail_d;
    end
  end
  assign bus.siren       = state_q == ALARM;
  assign bus.chime       = state_q == EXIT || state_q == ENTRY;
  assign bus.arm_fail    = arm_fail_q;
  assign bus.state       = state_q;
  assign bus.alarm_zones = az_q;
endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// tb_alarm_zone_ctrl: directed scoreboard bench for the alarm controller
module tb_alarm_zone_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    string      tag;
    logic [9:0] exp;
  } item_t;
  item_t sb[$];
  alarm_zone_ctrl_if #(.N_ZONES(4)) bus ();
  alarm_zone_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [9:0] pk(logic [2:0] s, logic af, logic [3:0] az);
    return {s, s == 3'd4, (s == 3'd1) || (s == 3'd3), af, az};
  endfunction
  task automatic step(string tag, int n, logic [2:0] s, logic af, logic [3:0] az);
    item_t      it;
    logic [9:0] obs;
    sb.push_back('{tag, pk(s, af, az)});
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    it  = sb.pop_front();
    obs = {bus.state, bus.siren, bus.chime, bus.arm_fail, bus.alarm_zones};
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s observed={st,sir,chm,af,az}=%b expected=%b", it.tag, obs, it.exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus.zone_in = 4'hF; bus.zone_en = 4'hF; bus.panic = 1'b1; bus.arm = 1'b0; bus.disarm = 1'b0;
    step("rst0", 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 0);
    step("rst2", 1, 0, 0, 0);
    rst_n = 1'b1; bus.zone_in = 4'h0; bus.panic = 1'b0;
    step("rst_release", 1, 0, 0, 0);
    bus.zone_in = 4'b0100;
    step("af_pre", 6, 0, 0, 0);
    bus.arm = 1'b1;
    step("af_pulse", 1, 0, 1, 0);
    bus.arm = 1'b0;
    step("af_one_cycle", 1, 0, 0, 0);
    bus.zone_in = 4'h0;
    step("clr1", 4, 0, 0, 0);
    bus.arm = 1'b1;
    step("exit_enter", 1, 1, 0, 0);
    bus.arm = 1'b0;
    step("exit_hold", 31, 1, 0, 0);
    step("armed", 1, 2, 0, 0);
    bus.zone_in = 4'b0010;
    step("glitch", 3, 2, 0, 0);
    bus.zone_in = 4'h0;
    step("glitch_ignored", 6, 2, 0, 0);
    bus.zone_in = 4'b0010;
    step("deb_pre", 6, 2, 0, 0);
    step("deb_alarm", 1, 4, 0, 4'b0010);
    step("siren_hold", 63, 4, 0, 4'b0010);
    step("silenced", 1, 5, 0, 4'b0010);
    bus.zone_in = 4'h0;
    step("z1_low", 4, 5, 0, 4'b0010);
    bus.zone_in = 4'b0010;
    step("z1_no_retrigger", 8, 5, 0, 4'b0010);
    bus.zone_in = 4'b1010;
    step("z3_pre", 6, 5, 0, 4'b0010);
    step("z3_retrigger", 1, 4, 0, 4'b1010);
    step("z3_siren", 63, 4, 0, 4'b1010);
    step("z3_silenced", 1, 5, 0, 4'b1010);
    bus.disarm = 1'b1;
    step("disarm_sil", 1, 0, 0, 0);
    bus.disarm = 1'b0; bus.zone_in = 4'h0;
    step("clr2", 4, 0, 0, 0);
    bus.arm = 1'b1;
    step("exit2", 1, 1, 0, 0);
    bus.arm = 1'b0;
    step("armed2", 32, 2, 0, 0);
    bus.zone_en = 4'b1101; bus.zone_in = 4'b0010;
    step("masked", 8, 2, 0, 0);
    bus.zone_en = 4'hF;
    step("unmask_alarm", 1, 4, 0, 4'b0010);
    bus.disarm = 1'b1;
    step("disarm_alarm", 1, 0, 0, 0);
    bus.disarm = 1'b0; bus.zone_in = 4'h0;
    step("clr3", 4, 0, 0, 0);
    bus.arm = 1'b1;
    step("exit3", 1, 1, 0, 0);
    bus.arm = 1'b0;
    step("armed3", 32, 2, 0, 0);
    bus.zone_in = 4'b0001;
    step("entry_pre", 6, 2, 0, 0);
    step("entry", 1, 3, 0, 0);
    bus.zone_in = 4'h0;
    step("entry_no_cancel", 9, 3, 0, 0);
    bus.disarm = 1'b1;
    step("entry_disarm", 1, 0, 0, 0);
    bus.disarm = 1'b0;
    step("clr4", 4, 0, 0, 0);
    bus.arm = 1'b1;
    step("exit4", 1, 1, 0, 0);
    bus.arm = 1'b0;
    step("armed4", 32, 2, 0, 0);
    bus.zone_in = 4'b0001;
    step("entry2_pre", 6, 2, 0, 0);
    step("entry2", 1, 3, 0, 0);
    step("entry2_hold", 15, 3, 0, 0);
    step("entry_timeout", 1, 4, 0, 4'b0001);
    bus.disarm = 1'b1; bus.zone_in = 4'h0;
    step("disarm_entry_alarm", 1, 0, 0, 0);
    bus.disarm = 1'b0; bus.panic = 1'b1;
    step("panic_sync", 2, 0, 0, 0);
    step("panic_alarm", 1, 4, 0, 0);
    step("panic_held", 10, 4, 0, 0);
    bus.panic = 1'b0;
    step("panic_no_restart", 53, 4, 0, 0);
    step("panic_silenced", 1, 5, 0, 0);
    bus.arm = 1'b1; bus.disarm = 1'b1;
    step("arm_and_disarm", 1, 0, 0, 0);
    step("arm_and_disarm_hold", 1, 0, 0, 0);
    bus.arm = 1'b0; bus.disarm = 1'b0;
    step("idle", 1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
